// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and coordinate type.
// Used by the sync generator, pixel generators and later display blocks.
package vga_timing_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 2;
    localparam int unsigned DIV_W           = 4;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // True when pos lies in [lo, lo+len).
    function automatic logic in_window(coord_t pos, int unsigned lo, int unsigned len);
        return (32'(pos) >= lo) && (32'(pos) < lo + len);
    endfunction

endpackage

// File: rtl/pixel_tick_divider.sv
// Integer clock divider: advance is high for one clk out of every CLK_DIV.
// Supports CLK_DIV in 1..16; CLK_DIV=1 keeps advance permanently high.
module pixel_tick_divider
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic advance
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt;

    assign advance = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (advance) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

endmodule

// File: rtl/vga_sync_generator.sv
// Raster timing source: walks the H_TOTAL x V_TOTAL raster at the divided pixel rate and
// registers coordinates, blanking and active-low syncs together so they stay aligned.
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = CLK_DIV_DEFAULT,
    parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic   clk,
    input  logic   reset,
    output logic   HSYNC,
    output logic   VSYNC,
    output logic   Video_On,
    output coord_t X_PIX,
    output coord_t Y_PIX,
    output logic   Pixel_Tick,
    output logic   Frame_Start
);

    localparam int unsigned H_PERIOD = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_PERIOD = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t      H_LAST   = coord_t'(H_PERIOD - 1);
    localparam coord_t      V_LAST   = coord_t'(V_PERIOD - 1);
    localparam coord_t      ONE      = coord_t'(1);

    logic   advance;
    coord_t h_cnt, v_cnt;
    coord_t h_nxt, v_nxt;

    pixel_tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_divider (
        .clk     (clk),
        .reset   (reset),
        .advance (advance)
    );

    always_comb begin
        h_nxt = h_cnt + ONE;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
        end
    end

    // Counters start at the last raster position so the first advance lands on (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            X_PIX       <= '0;
            Y_PIX       <= '0;
            Video_On    <= 1'b0;
            HSYNC       <= 1'b1;
            VSYNC       <= 1'b1;
            Pixel_Tick  <= 1'b0;
            Frame_Start <= 1'b0;
        end else if (advance) begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            X_PIX       <= h_nxt;
            Y_PIX       <= v_nxt;
            Video_On    <= (32'(h_nxt) < H_DISPLAY) && (32'(v_nxt) < V_DISPLAY);
            HSYNC       <= !in_window(h_nxt, H_DISPLAY + H_FRONT, H_SYNC);
            VSYNC       <= !in_window(v_nxt, V_DISPLAY + V_FRONT, V_SYNC);
            Pixel_Tick  <= 1'b1;
            Frame_Start <= (h_nxt == '0) && (v_nxt == '0);
        end else begin
            Pixel_Tick  <= 1'b0;
            Frame_Start <= 1'b0;
        end
    end

endmodule
